// File: rtl/product_pkg.sv
// Shared types and defaults for the sequential nibble-fed multiplier.
package product_pkg;

    localparam int DEF_NIB_W  = 4;
    localparam int DEF_N_NIBS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Width of byte_sel: enough to address every product byte, never below 1.
    function automatic int sel_width(input int nib_w, input int n_nibs);
        int n_bytes;
        n_bytes = (2 * nib_w * n_nibs) / 8;
        return (n_bytes <= 2) ? 1 : $clog2(n_bytes);
    endfunction

endpackage

// File: rtl/product_seq_mult_if.sv
// Pin-style bus between the tile wrapper and the multiplier core.
interface product_seq_mult_if
    import product_pkg::*;
#(
    parameter int NIB_W  = DEF_NIB_W,
    parameter int N_NIBS = DEF_N_NIBS
);
    localparam int SEL_W = sel_width(NIB_W, N_NIBS);

    logic [NIB_W-1:0] nibble;
    logic             load_a;
    logic             load_b;
    logic             signed_mode;
    logic             start;
    logic [SEL_W-1:0] byte_sel;
    logic             busy;
    logic             done;
    logic [7:0]       result;

    modport master (
        output nibble, load_a, load_b, signed_mode, start, byte_sel,
        input  busy, done, result
    );

    modport slave (
        input  nibble, load_a, load_b, signed_mode, start, byte_sel,
        output busy, done, result
    );

endinterface

// File: rtl/product_operand_sr.sv
// Operand register fed MS nibble first; older nibbles move toward the MSB.
module product_operand_sr
    import product_pkg::*;
#(
    parameter int NIB_W  = DEF_NIB_W,
    parameter int N_NIBS = DEF_N_NIBS
) (
    input  logic                      clk,
    input  logic                      i_clr,
    input  logic                      i_en,
    input  logic [NIB_W-1:0]          i_nibble,
    output logic [NIB_W*N_NIBS-1:0]   o_q
);
    localparam int W = NIB_W * N_NIBS;

    logic [W-1:0] r_q;

    // Synchronous clear has priority over a shift.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= (r_q << NIB_W) | W'(i_nibble);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/product_seq_mult.sv
// Sequential shift-add multiplier: nibble-loaded operands, W-cycle multiply,
// sign fix-up cycle, byte-wide readback of the 2W-bit product.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting; operand loads accepted
// ST_RUN  | one multiplier bit consumed per edge, W edges total
// ST_FIX  | apply latched sign to accumulator, write product register
// ST_DONE | product valid; loads accepted (and drop back to IDLE)
module product_seq_mult
    import product_pkg::*;
#(
    parameter int NIB_W  = DEF_NIB_W,
    parameter int N_NIBS = DEF_N_NIBS
) (
    input  logic               clk,
    input  logic               reset,
    product_seq_mult_if.slave  bus
);
    localparam int W       = NIB_W * N_NIBS;
    localparam int P_W     = 2 * W;
    localparam int N_BYTES = P_W / 8;
    localparam int SEL_W   = sel_width(NIB_W, N_NIBS);
    localparam int CNT_W   = $clog2(W + 1);

    if ((P_W % 8) != 0) begin : g_bad_width
        $error("product_seq_mult: 2*NIB_W*N_NIBS must be a multiple of 8");
    end

    state_t           r_state;
    state_t           w_state_nxt;

    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic [W-1:0]     w_mag_a;
    logic [W-1:0]     w_mag_b;
    logic             w_accept;
    logic             w_start_ok;
    logic             w_load_ok;
    logic             w_last_bit;

    logic [P_W-1:0]   r_mcand;
    logic [W-1:0]     r_mplier;
    logic [P_W-1:0]   r_acc;
    logic [P_W-1:0]   r_prod;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign;
    logic [7:0]       w_result;

    // Start and loads are only honoured between multiplies; start beats a load.
    assign w_accept   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start_ok = w_accept && bus.start;
    assign w_load_ok  = w_accept && !bus.start;
    assign w_last_bit = (r_state == ST_RUN) && (r_cnt == CNT_W'(1));

    product_operand_sr #(
        .NIB_W  (NIB_W),
        .N_NIBS (N_NIBS)
    ) u_opnd_a (
        .clk      (clk),
        .i_clr    (reset),
        .i_en     (w_load_ok && bus.load_a),
        .i_nibble (bus.nibble),
        .o_q      (w_a)
    );

    product_operand_sr #(
        .NIB_W  (NIB_W),
        .N_NIBS (N_NIBS)
    ) u_opnd_b (
        .clk      (clk),
        .i_clr    (reset),
        .i_en     (w_load_ok && bus.load_b),
        .i_nibble (bus.nibble),
        .o_q      (w_b)
    );

    // Magnitudes: -2^(W-1) negates to itself, which is the correct unsigned magnitude.
    assign w_mag_a = (bus.signed_mode && w_a[W-1]) ? -w_a : w_a;
    assign w_mag_b = (bus.signed_mode && w_b[W-1]) ? -w_b : w_b;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an accepted load in DONE withdraws the result.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_bit) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                end else if (bus.load_a || bus.load_b) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift-add datapath; the counter runs down from W and ends RUN at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_sign   <= bus.signed_mode && (w_a[W-1] ^ w_b[W-1]);
                r_mcand  <= P_W'(w_mag_a);
                r_mplier <= w_mag_b;
                r_acc    <= '0;
                r_cnt    <= CNT_W'(W);
            end else if (r_state == ST_RUN) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CNT_W'(1);
            end else if (r_state == ST_FIX) begin
                r_prod <= r_sign ? -r_acc : r_acc;
            end
        end
    end

    // Byte readback; selects past the top byte read as zero.
    always_comb begin
        w_result = 8'h00;
        for (int i = 0; i < N_BYTES; i++) begin
            if (bus.byte_sel == SEL_W'(i)) begin
                w_result = r_prod[8*i +: 8];
            end
        end
    end

    assign bus.result = w_result;
    assign bus.busy   = (r_state == ST_RUN) || (r_state == ST_FIX);
    assign bus.done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_product_seq_mult.sv
// Directed and randomised checks of the sequential multiplier at W=8 and W=16.
module tb_product_seq_mult;
    import product_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    product_seq_mult_if #(.NIB_W(4), .N_NIBS(2)) bus8 ();
    product_seq_mult_if #(.NIB_W(4), .N_NIBS(4)) bus16 ();

    product_seq_mult #(.NIB_W(4), .N_NIBS(2)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    product_seq_mult #(.NIB_W(4), .N_NIBS(4)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer product of the operands as read under the sign mode, mod 2^(2w).
    function automatic longint model(input longint a, input longint b, input bit sgn, input int w);
        longint sa;
        longint sb;
        longint mask;
        sa = a;
        sb = b;
        if (sgn && a >= (longint'(1) << (w - 1))) sa = a - (longint'(1) << w);
        if (sgn && b >= (longint'(1) << (w - 1))) sb = b - (longint'(1) << w);
        mask = (longint'(1) << (2 * w)) - 1;
        return (sa * sb) & mask;
    endfunction

    task automatic load8(input logic [7:0] a, input logic [7:0] b);
        bus8.load_a = 1'b1;
        bus8.nibble = a[7:4]; tick();
        bus8.nibble = a[3:0]; tick();
        bus8.load_a = 1'b0;
        bus8.load_b = 1'b1;
        bus8.nibble = b[7:4]; tick();
        bus8.nibble = b[3:0]; tick();
        bus8.load_b = 1'b0;
    endtask

    task automatic start8(input bit sgn);
        bus8.signed_mode = sgn;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (bus8.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic read8(output logic [15:0] p);
        bus8.byte_sel = 1'b0; #1;
        p[7:0] = bus8.result;
        bus8.byte_sel = 1'b1; #1;
        p[15:8] = bus8.result;
        bus8.byte_sel = 1'b0;
    endtask

    task automatic load16(input logic [15:0] a, input logic [15:0] b);
        bus16.load_a = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            bus16.nibble = a[4*i +: 4]; tick();
        end
        bus16.load_a = 1'b0;
        bus16.load_b = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            bus16.nibble = b[4*i +: 4]; tick();
        end
        bus16.load_b = 1'b0;
    endtask

    task automatic run16(input bit sgn, output int cyc);
        bus16.signed_mode = sgn;
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        cyc = 0;
        while (bus16.done !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic read16(output logic [31:0] p);
        for (int i = 0; i < 4; i++) begin
            bus16.byte_sel = 2'(i); #1;
            p[8*i +: 8] = bus16.result;
        end
        bus16.byte_sel = 2'd0;
    endtask

    initial begin
        logic [15:0] p8;
        logic [31:0] p16;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] wa;
        logic [15:0] wb;
        bit          sg;
        int          cyc;

        bus8.nibble = '0;  bus8.load_a = 0;  bus8.load_b = 0;
        bus8.signed_mode = 0;  bus8.start = 0;  bus8.byte_sel = '0;
        bus16.nibble = '0; bus16.load_a = 0; bus16.load_b = 0;
        bus16.signed_mode = 0; bus16.start = 0; bus16.byte_sel = '0;
        reset = 1'b1;
        tick();
        tick();

        check("reset_busy", 64'(bus8.busy), 64'd0);
        check("reset_done", 64'(bus8.done), 64'd0);
        read8(p8);
        check("reset_result", 64'(p8), 64'h0);
        reset = 1'b0;
        tick();

        // Case 1: 0x0D * 0x0B unsigned.
        load8(8'h0D, 8'h0B);
        start8(1'b0);
        check("c1_busy", 64'(bus8.busy), 64'd1);
        wait_done8(cyc);
        check("c1_latency", 64'(cyc), 64'd9);
        read8(p8);
        check("c1_byte0", 64'(p8[7:0]), 64'h8F);
        check("c1_byte1", 64'(p8[15:8]), 64'h00);
        tick(); tick();
        check("c1_done_held", 64'(bus8.done), 64'd1);

        // Case 2: 0xFF * 0xFF, unsigned then signed.
        load8(8'hFF, 8'hFF);
        check("load_clears_done", 64'(bus8.done), 64'd0);
        start8(1'b0);
        wait_done8(cyc);
        read8(p8);
        check("c2_unsigned", 64'(p8), 64'hFE01);
        start8(1'b1);
        wait_done8(cyc);
        read8(p8);
        check("c2_signed", 64'(p8), 64'h0001);

        // Case 3: signed extremes.
        load8(8'h80, 8'h80);
        start8(1'b1);
        wait_done8(cyc);
        read8(p8);
        check("c3_min_min", 64'(p8), 64'h4000);
        load8(8'h80, 8'h7F);
        start8(1'b1);
        wait_done8(cyc);
        read8(p8);
        check("c3_min_max", 64'(p8), 64'hC080);

        // Case 4a: prior product held until FIX; start/load_a during RUN ignored.
        load8(8'h0D, 8'h0B);
        read8(p8);
        check("c4_hold_before_start", 64'(p8), 64'hC080);
        start8(1'b0);
        tick(); tick(); tick();
        read8(p8);
        check("c4_hold_during_run", 64'(p8), 64'hC080);
        bus8.start = 1'b1; bus8.load_a = 1'b1; bus8.nibble = 4'hF;
        tick();
        bus8.start = 1'b0; bus8.load_a = 1'b0;
        wait_done8(cyc);
        check("c4_latency_with_noise", 64'(cyc + 4), 64'd9);
        read8(p8);
        check("c4_run_noise_ignored", 64'(p8), 64'h008F);
        start8(1'b0);
        wait_done8(cyc);
        read8(p8);
        check("c4_operand_a_kept", 64'(p8), 64'h008F);

        // Case 4b: start with simultaneous load_b drops the load.
        load8(8'h03, 8'h05);
        bus8.signed_mode = 1'b0;
        bus8.start = 1'b1; bus8.load_b = 1'b1; bus8.nibble = 4'h7;
        tick();
        bus8.start = 1'b0; bus8.load_b = 1'b0;
        wait_done8(cyc);
        read8(p8);
        check("c4_start_beats_load", 64'(p8), 64'h000F);

        // Case 5: reset in the middle of RUN.
        load8(8'hC3, 8'h5A);
        start8(1'b0);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("c5_busy", 64'(bus8.busy), 64'd0);
        check("c5_done", 64'(bus8.done), 64'd0);
        read8(p8);
        check("c5_result", 64'(p8), 64'h0);
        tick();
        check("c5_still_idle", 64'(bus8.busy), 64'd0);
        load8(8'hC3, 8'h5A);
        start8(1'b1);
        wait_done8(cyc);
        read8(p8);
        check("c5_fresh", 64'(p8), 64'(model(64'hC3, 64'h5A, 1'b1, 8)));

        // Randomised W=8 operands against the arithmetic model.
        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            sg = 1'($urandom_range(0, 1));
            load8(ra, rb);
            start8(sg);
            wait_done8(cyc);
            check("rand8_latency", 64'(cyc), 64'd9);
            read8(p8);
            check($sformatf("rand8_%0h_%0h_s%0d", ra, rb, sg), 64'(p8),
                  64'(model(64'(ra), 64'(rb), sg, 8)));
        end

        // Case 6: W=16 instance.
        load16(16'hFFFF, 16'hFFFF);
        run16(1'b0, cyc);
        check("c6_latency", 64'(cyc), 64'd17);
        read16(p16);
        check("c6_ffff_sq", 64'(p16), 64'hFFFE0001);
        for (int k = 0; k < 6; k++) begin
            wa = 16'($urandom_range(0, 65535));
            wb = 16'($urandom_range(0, 65535));
            sg = 1'($urandom_range(0, 1));
            load16(wa, wb);
            run16(sg, cyc);
            check("rand16_latency", 64'(cyc), 64'd17);
            read16(p16);
            check($sformatf("rand16_%0h_%0h_s%0d", wa, wb, sg), 64'(p16),
                  64'(model(64'(wa), 64'(wb), sg, 16)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
